mdu_hilo: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits downstream of the general register file: consumes its two read ports (rs, rt values) and the decoded MDU control.
- Exports HI/LO to the writeback mux for mfhi/mflo.
- Asserts busy so the controller stalls dependent MDU instructions.

---
 rtl/mdu_hilo_if.sv | 20 ++
 rtl/mdu_hilo.sv | 121 ++++++++++++
 tb/tb_mdu_hilo.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - issue/result bundle between the controller and the HI/LO multiply-divide unit
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, op, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - fixed-latency multiply/divide unit with architectural HI/LO registers
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_hilo_if.slave   bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [1:0]     op_q;     // 0=mult 1=multu 2=div 3=divu
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic           busy_q;

    logic [63:0]    prod_s;
    logic [63:0]    prod_u;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;
    logic           res_we;

    assign bus.busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    // Result of the latched operation; the latched operands are stable for the whole run.
    always_comb begin
        prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_we = 1'b1;
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_we = 1'b1;
            end
            2'd2: begin
                // Most-negative / -1 wraps; handled explicitly rather than trusting the divider.
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'h0000_0000;
                    res_we = 1'b1;
                end else begin
                    res_lo = $signed(a_q) / $signed(b_q);
                    res_hi = $signed(a_q) % $signed(b_q);
                    res_we = 1'b1;
                end
            end
            default: begin
                if (b_q != 32'd0) begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                    res_we = 1'b1;
                end
            end
        endcase
    end

    // Issue/run FSM: latches operands, counts down the busy window, commits HI/LO on the last edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                a_q    <= bus.A;
                                b_q    <= bus.B;
                                op_q   <= bus.op[1:0];
                                count  <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                                busy_q <= 1'b1;
                                state  <= RUN;
                            end
                            3'd4:    hi_q <= bus.A;
                            3'd5:    lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        if (res_we) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed self-checking bench for mdu_hilo
module tb_mdu_hilo;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mdu_hilo_if bus ();

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an iterative op, scramble A/B while busy, optionally pulse a stray mtlo,
    // and check busy length, HI/LO held during the run, and the final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit interfere);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cnt;
        int          hold_bad;
        old_hi    = bus.HI;
        old_lo    = bus.LO;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        cnt       = 0;
        hold_bad  = 0;
        while (bus.busy && cnt < 50) begin
            cnt++;
            if (bus.HI !== old_hi || bus.LO !== old_lo) hold_bad++;
            bus.A = $urandom;
            bus.B = $urandom;
            bus.op = 3'($urandom_range(0, 7));
            if (interfere && cnt == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd5;
                bus.A     = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        check({tag, " busy_cycles"}, 32'(cnt), 32'(n));
        check({tag, " hold_during_run"}, 32'(hold_bad), 32'd0);
        check({tag, " HI"}, bus.HI, exp_hi);
        check({tag, " LO"}, bus.LO, exp_lo);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = 32'h0;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = 32'h0;
        bus.B     = 32'h0;
        tick();
        tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset HI", bus.HI, 32'h0);
        check("reset LO", bus.LO, 32'h0);
        reset = 1'b1;
        tick();

        run_op("mult -2*3",     3'd0, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu fffe*3",  3'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        run_op("div -7/2",      3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu fff9/2",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        run_op("div overflow",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0);

        move_to(3'd4, 32'h1234_5678);
        check("mthi HI", bus.HI, 32'h1234_5678);
        check("mthi LO untouched", bus.LO, 32'h8000_0000);
        check("mthi busy", 32'(bus.busy), 32'd0);
        move_to(3'd5, 32'h9ABC_DEF0);
        check("mtlo LO", bus.LO, 32'h9ABC_DEF0);
        check("mtlo HI untouched", bus.HI, 32'h1234_5678);

        run_op("divu by zero", 3'd3, 32'h0000_0064, 32'h0, 10, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        move_to(3'd6, 32'hFFFF_FFFF);
        tick();
        check("reserved busy", 32'(bus.busy), 32'd0);
        check("reserved HI", bus.HI, 32'h1234_5678);
        check("reserved LO", bus.LO, 32'h9ABC_DEF0);

        run_op("mult 6*7 interfered", 3'd0, 32'd6, 32'd7, 5, 32'h0, 32'h0000_002A, 1'b1);

        // Reset lands in the third busy cycle of a divide.
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre-abort busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort HI", bus.HI, 32'h0);
        check("abort LO", bus.LO, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        check("post-abort busy", 32'(bus.busy), 32'd0);
        check("post-abort HI", bus.HI, 32'h0);
        check("post-abort LO", bus.LO, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
